vid_seq: RTL and testbench

VID_SEQ -- requirements
Module: vid_seq

---
 rtl/vid_seq.sv | 169 ++++++++++++++++
 tb/tb_vid_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_seq.sv
// vid_seq -- sequencer for the vector "vid" (element index) instruction.
//
// Accepts one vid request (sew, vl, vd), splits it into DATA_WIDTH-wide beats
// and issues one beat per unstalled cycle to the datapath. Each beat carries
// the index of its first element and its destination register. After the last
// beat has issued, the sequencer waits for every beat to come back from the
// datapath (vid_ret_valid pulses) and then pulses done.
//
// Optional feature: define VID_SEQ_SEW64_EN to accept sew=3 (64-bit elements,
// one element per beat). Without it, sew=3 is consumed and reported with err.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready request handshake; req_ready is high only in IDLE
//   req_sew/vl/vd   element width code, element count, first dest register
//   issue_stall     register port busy; suppresses vid_valid this cycle
//   vid_valid       beat issued (combinationally gated by issue_stall)
//   vid_sew         latched sew
//   vid_start_idx   first element index of the current beat
//   vid_addr        destination register of the current beat
//   vid_ret_valid   datapath output-valid, one pulse per beat
//   busy            high in ISSUE or DRAIN
//   done            one-cycle completion pulse
//   err             one-cycle illegal-request pulse
//
// Handshake: a request transfers in any cycle where req_valid && req_ready are
// both high at the rising edge of clk; the requester holds its fields stable
// until then. vid_valid has no ready: issue_stall is the backpressure and the
// beat fields stay unchanged while it is high.
module vid_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int SEW_WIDTH  = 2,
    parameter int VL_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEW_WIDTH-1:0]  req_sew,
    input  logic [VL_WIDTH-1:0]   req_vl,
    input  logic [ADDR_WIDTH-1:0] req_vd,
    input  logic                  issue_stall,
    output logic                  vid_valid,
    output logic [SEW_WIDTH-1:0]  vid_sew,
    output logic [VL_WIDTH-1:0]   vid_start_idx,
    output logic [ADDR_WIDTH-1:0] vid_addr,
    input  logic                  vid_ret_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LG_BYTES = $clog2(DATA_WIDTH / 8);
    localparam int CW       = VL_WIDTH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nxt;

    logic [SEW_WIDTH-1:0]  sew_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [VL_WIDTH-1:0]   start_q;
    logic [CW-1:0]         beat_total;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         ret_cnt;
    logic                  zero_done_q;
    logic                  err_q;

    // log2(elements per beat) for a sew code.
    function automatic logic [7:0] epb_shift(input logic [SEW_WIDTH-1:0] s);
        return 8'(LG_BYTES) - 8'(s);
    endfunction

    logic          sew_legal;
    logic [7:0]    req_sh;
    logic [CW-1:0] req_epb;
    logic [CW-1:0] req_beats;
    logic [VL_WIDTH-1:0] cur_epb;

`ifdef VID_SEQ_SEW64_EN
    assign sew_legal = 1'b1;
`else
    assign sew_legal = (req_sew != SEW_WIDTH'(3));
`endif

    // EPB is a power of two, so ceil(vl/EPB) is an add and a shift.
    assign req_sh    = epb_shift(req_sew);
    assign req_epb   = CW'(1) << req_sh;
    assign req_beats = ({1'b0, req_vl} + req_epb - CW'(1)) >> req_sh;
    assign cur_epb   = VL_WIDTH'(1) << epb_shift(sew_q);

    logic          accept, acc_go, acc_zero, acc_bad;
    logic          issue_fire, last_issue;
    logic          ret_en, drain_done;
    logic [CW-1:0] ret_cnt_nxt;

    assign accept     = (state == IDLE) && req_valid;
    assign acc_go     = accept && sew_legal && (req_vl != '0);
    assign acc_zero   = accept && sew_legal && (req_vl == '0);
    assign acc_bad    = accept && !sew_legal;
    assign issue_fire = (state == ISSUE) && !issue_stall;
    assign last_issue = issue_fire && (issue_cnt == beat_total - CW'(1));
    assign ret_en     = vid_ret_valid && (state != IDLE);
    // Include this cycle's return so the final pulse and done share a cycle.
    assign ret_cnt_nxt = ret_cnt + CW'(ret_en);
    assign drain_done  = (state == DRAIN) && (ret_cnt_nxt == beat_total);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_go)     state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        req_ready     = (state == IDLE);
        busy          = (state != IDLE);
        vid_valid     = issue_fire;
        vid_sew       = sew_q;
        vid_start_idx = start_q;
        vid_addr      = addr_q;
        done          = (drain_done || zero_done_q) && !rst;
        err           = err_q;
    end

    // Latches and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sew_q       <= '0;
            addr_q      <= '0;
            start_q     <= '0;
            beat_total  <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            zero_done_q <= acc_zero;
            err_q       <= acc_bad;
            if (acc_go) begin
                sew_q      <= req_sew;
                addr_q     <= req_vd;
                start_q    <= '0;
                beat_total <= req_beats;
                issue_cnt  <= '0;
                ret_cnt    <= '0;
            end else begin
                if (issue_fire) begin
                    start_q   <= start_q + cur_epb;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                    issue_cnt <= issue_cnt + CW'(1);
                end
                if (ret_en) ret_cnt <= ret_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vid_seq.sv
// Testbench for vid_seq: directed requests, a 6-cycle datapath model that
// echoes vid_valid back on vid_ret_valid, and a queue of expected beats.
module tb_vid_seq;

    localparam int W = 19;   // {sew[1:0], start_idx[11:0], addr[4:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sew = '0;
    logic [11:0] req_vl = '0;
    logic [4:0]  req_vd = '0;
    logic        issue_stall = 1'b0;
    logic        vid_valid;
    logic [1:0]  vid_sew;
    logic [11:0] vid_start_idx;
    logic [4:0]  vid_addr;
    logic        vid_ret_valid;
    logic        busy, done, err;

    logic [W-1:0] exp_q[$];
    logic [5:0]   pipe = '0;
    logic         ret_inject = 1'b0;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cnt = 0, err_cnt = 0, beat_cnt = 0;
    int done_cyc = 0, last_beat_cyc = 0;
    bit mon_en = 1'b0;

    vid_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sew(req_sew), .req_vl(req_vl), .req_vd(req_vd),
        .issue_stall(issue_stall),
        .vid_valid(vid_valid), .vid_sew(vid_sew),
        .vid_start_idx(vid_start_idx), .vid_addr(vid_addr),
        .vid_ret_valid(vid_ret_valid),
        .busy(busy), .done(done), .err(err)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Six-stage datapath model.
    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[4:0], vid_valid};
    end
    assign vid_ret_valid = pipe[5] | ret_inject;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assert_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("busy_vs_ready", 64'(busy), 64'(!req_ready));
            chk("done_err_excl", 64'(done & err), 64'(0));
            if (vid_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("beat", 64'({vid_sew, vid_start_idx, vid_addr}), 64'(e));
                end
                beat_cnt++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
        end
    end

    // Driver: call at posedge+1; request is taken at the next rising edge.
    task automatic send(input logic [1:0] s, input logic [11:0] vl, input logic [4:0] vd,
                        input bit chk_rst);
        bit legal;
        int epb, nb;
        req_valid = 1'b1;
        req_sew   = s;
        req_vl    = vl;
        req_vd    = vd;
        @(negedge clk);
        req_cyc = cyc;
        if (chk_rst) begin
            chk("rst_vid_valid", 64'(vid_valid), 64'(0));
            chk("rst_start_idx", 64'(vid_start_idx), 64'(0));
            chk("rst_addr", 64'(vid_addr), 64'(0));
            chk("rst_sew", 64'(vid_sew), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
        end
        chk("req_ready", 64'(req_ready), 64'(1));
`ifdef VID_SEQ_SEW64_EN
        legal = 1'b1;
`else
        legal = (s != 2'd3);
`endif
        if (legal && vl != 0) begin
            epb = 8 >> s;
            nb  = (int'(vl) + epb - 1) / epb;
            for (int n = 0; n < nb; n++) begin
                logic [11:0] si;
                logic [4:0]  ad;
                si = 12'(n * epb);
                ad = 5'(int'(vd) + n);
                exp_q.push_back({s, si, ad});
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", 64'(done_cnt != start), 64'(1));
        #1;
    endtask

    initial begin
        int b0, d0, e0;

        // Reset.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        chk("reset_vid_valid", 64'(vid_valid), 64'(0));
        chk("reset_start_idx", 64'(vid_start_idx), 64'(0));
        chk("reset_addr", 64'(vid_addr), 64'(0));
        chk("reset_sew", 64'(vid_sew), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // sew=0, vl=20, vd=4: three consecutive beats, done 6 cycles after last.
        b0 = beat_cnt;
        send(2'd0, 12'd20, 5'd4, 1'b0);
        wait_done(40);
        chk("t1_beats", 64'(beat_cnt - b0), 64'(3));
        chk("t1_last_beat_cyc", 64'(last_beat_cyc - req_cyc), 64'(3));
        chk("t1_done_lat", 64'(done_cyc - last_beat_cyc), 64'(6));
        chk("t1_q_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        chk("t1_busy_after", 64'(busy), 64'(0));

        // sew=2, vl=5, vd=30: address wraps v31 -> v0.
        b0 = beat_cnt;
        send(2'd2, 12'd5, 5'd30, 1'b0);
        wait_done(40);
        chk("t2_beats", 64'(beat_cnt - b0), 64'(3));
        chk("t2_done_lat", 64'(done_cyc - last_beat_cyc), 64'(6));

        // Returns while IDLE are ignored: single-beat request still needs its own.
        ret_inject = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ret_inject = 1'b0;
        send(2'd2, 12'd2, 5'd3, 1'b0);
        wait_done(40);
        chk("t3_done_lat", 64'(done_cyc - last_beat_cyc), 64'(6));
        chk("t3_req_to_done", 64'(done_cyc - req_cyc), 64'(7));

        // sew=1, vl=9, three stall cycles after beat 0.
        b0 = beat_cnt;
        send(2'd1, 12'd9, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(vid_valid), 64'(0));
            chk("stall_start_idx", 64'(vid_start_idx), 64'(4));
            chk("stall_addr", 64'(vid_addr), 64'(1));
            chk("stall_sew", 64'(vid_sew), 64'(1));
            @(posedge clk);
            #1;
        end
        issue_stall = 1'b0;
        wait_done(40);
        chk("t4_beats", 64'(beat_cnt - b0), 64'(3));
        chk("t4_done_lat", 64'(done_cyc - last_beat_cyc), 64'(6));

        // vl=0: done next cycle, no beat, never busy.
        b0 = beat_cnt;
        d0 = done_cnt;
        send(2'd1, 12'd0, 5'd9, 1'b0);
        @(negedge clk);
        chk("vl0_done", 64'(done), 64'(1));
        chk("vl0_busy", 64'(busy), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        chk("vl0_no_beat", 64'(beat_cnt - b0), 64'(0));
        chk("vl0_one_done", 64'(done_cnt - d0), 64'(1));

        // sew=3, vl=2, vd=10.
        b0 = beat_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        send(2'd3, 12'd2, 5'd10, 1'b0);
`ifdef VID_SEQ_SEW64_EN
        wait_done(40);
        chk("sew3_beats", 64'(beat_cnt - b0), 64'(2));
        chk("sew3_no_err", 64'(err_cnt - e0), 64'(0));
`else
        @(negedge clk);
        chk("sew3_err", 64'(err), 64'(1));
        repeat (12) @(posedge clk);
        #1;
        chk("sew3_no_beat", 64'(beat_cnt - b0), 64'(0));
        chk("sew3_no_done", 64'(done_cnt - d0), 64'(0));
        chk("sew3_one_err", 64'(err_cnt - e0), 64'(1));
`endif

        // rst two cycles into ISSUE; a request during rst is dropped.
        d0 = done_cnt;
        send(2'd0, 12'd64, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_sew   = 2'd0;
        req_vl    = 12'd0;
        req_vd    = 5'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        b0 = beat_cnt;
        send(2'd2, 12'd3, 5'd7, 1'b1);
        wait_done(40);
        chk("rst_new_beats", 64'(beat_cnt - b0), 64'(2));
        chk("rst_new_req_to_done", 64'(done_cyc - req_cyc), 64'(8));
        repeat (12) @(posedge clk);
        #1;
        chk("rst_done_count", 64'(done_cnt - d0), 64'(1));
        chk("final_q_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
